// File: rtl/mem_rd_arbiter_if.sv
// Bundle of the icache, LSU and downstream AR/R channels around mem_rd_arbiter.
// "master" is the environment side (requesters plus memory); "slave" is the arbiter itself.
interface mem_rd_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              ic_arvalid;
  logic [ADDR_W-1:0] ic_araddr;
  logic              ic_arready;
  logic              ic_rvalid;
  logic [DATA_W-1:0] ic_rdata;
  logic [1:0]        ic_rresp;
  logic              ic_rready;

  logic              ls_arvalid;
  logic [ADDR_W-1:0] ls_araddr;
  logic [2:0]        ls_arsize;
  logic              ls_arready;
  logic              ls_rvalid;
  logic [DATA_W-1:0] ls_rdata;
  logic [1:0]        ls_rresp;
  logic              ls_rready;

  logic              out_arvalid;
  logic [ADDR_W-1:0] out_araddr;
  logic [2:0]        out_arsize;
  logic              out_arready;
  logic              out_rvalid;
  logic [DATA_W-1:0] out_rdata;
  logic [1:0]        out_rresp;
  logic              out_rready;

  modport master (
    output ic_arvalid, ic_araddr, ic_rready,
    output ls_arvalid, ls_araddr, ls_arsize, ls_rready,
    output out_arready, out_rvalid, out_rdata, out_rresp,
    input  ic_arready, ic_rvalid, ic_rdata, ic_rresp,
    input  ls_arready, ls_rvalid, ls_rdata, ls_rresp,
    input  out_arvalid, out_araddr, out_arsize, out_rready
  );

  modport slave (
    input  ic_arvalid, ic_araddr, ic_rready,
    input  ls_arvalid, ls_araddr, ls_arsize, ls_rready,
    input  out_arready, out_rvalid, out_rdata, out_rresp,
    output ic_arready, ic_rvalid, ic_rdata, ic_rresp,
    output ls_arready, ls_rvalid, ls_rdata, ls_rresp,
    output out_arvalid, out_araddr, out_arsize, out_rready
  );
endinterface

// File: rtl/mem_rd_arbiter.sv
// Two-requester (icache / LSU) arbiter for a single AXI-lite style read port, one transaction at a time.
// Default is strict LSU priority; define MEM_RD_ARB_RR_EN for round-robin on simultaneous requests.
module mem_rd_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  mem_rd_arbiter_if.slave      bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              grant_q, grant_d;
  logic              last_grant_q, last_grant_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic [2:0]        arsize_q, arsize_d;

  logic any_req, pick_ls, in_idle, ic_sel, ls_sel, out_rready_w;

  always_comb begin
    any_req = bus.ic_arvalid | bus.ls_arvalid;
`ifdef MEM_RD_ARB_RR_EN
    // On a tie the requester not served last wins; last_grant resets to icache so LSU takes the first tie.
    pick_ls = bus.ls_arvalid & (~bus.ic_arvalid | ~last_grant_q);
`else
    pick_ls = bus.ls_arvalid;
`endif
  end

`ifndef MEM_RD_ARB_RR_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant_q;
`endif

  // Gate with reset so no request is accepted while reset is held.
  assign in_idle      = (state_q == S_IDLE) & ~reset;
  assign ic_sel       = (state_q == S_DATA) & ~grant_q;
  assign ls_sel       = (state_q == S_DATA) &  grant_q;
  assign out_rready_w = (ic_sel & bus.ic_rready) | (ls_sel & bus.ls_rready);

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    araddr_d     = araddr_q;
    arsize_d     = arsize_q;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          grant_d      = pick_ls;
          last_grant_d = pick_ls;
          araddr_d     = pick_ls ? bus.ls_araddr : bus.ic_araddr;
          arsize_d     = pick_ls ? bus.ls_arsize : 3'b010;
          state_d      = S_ADDR;
        end
      end
      S_ADDR: if (bus.out_arready) state_d = S_DATA;
      S_DATA: if (bus.out_rvalid && out_rready_w) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b0;
      araddr_q     <= '0;
      arsize_q     <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      araddr_q     <= araddr_d;
      arsize_q     <= arsize_d;
    end
  end

  assign bus.ic_arready  = in_idle & bus.ic_arvalid & ~pick_ls;
  assign bus.ls_arready  = in_idle & pick_ls;

  assign bus.out_arvalid = (state_q == S_ADDR);
  assign bus.out_araddr  = araddr_q;
  assign bus.out_arsize  = arsize_q;
  assign bus.out_rready  = out_rready_w;

  // Only the granted requester in DATA sees the R channel; everything else reads as zero.
  assign bus.ic_rvalid   = ic_sel & bus.out_rvalid;
  assign bus.ic_rdata    = ic_sel ? bus.out_rdata : '0;
  assign bus.ic_rresp    = ic_sel ? bus.out_rresp : 2'b00;
  assign bus.ls_rvalid   = ls_sel & bus.out_rvalid;
  assign bus.ls_rdata    = ls_sel ? bus.out_rdata : '0;
  assign bus.ls_rresp    = ls_sel ? bus.out_rresp : 2'b00;

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// Self-checking bench for mem_rd_arbiter: directed scenarios plus a randomized transaction-level scoreboard.
module tb_mem_rd_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
`ifdef MEM_RD_ARB_RR_EN
  localparam bit RR_MODE = 1'b1;
`else
  localparam bit RR_MODE = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  mem_rd_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
  mem_rd_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (.clock(clock), .reset(reset), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;
  bit model_last_ls = 1'b0;

  // Reference arbitration rule: 1 = LSU wins.
  function automatic bit model_pick_ls(input bit ic_req, input bit ls_req);
    if (!ls_req) return 1'b0;
    if (!ic_req) return 1'b1;
    return RR_MODE ? !model_last_ls : 1'b1;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    bus.ic_arvalid = 0; bus.ic_araddr = '0; bus.ic_rready = 0;
    bus.ls_arvalid = 0; bus.ls_araddr = '0; bus.ls_arsize = '0; bus.ls_rready = 0;
    bus.out_arready = 0; bus.out_rvalid = 0; bus.out_rdata = '0; bus.out_rresp = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    bus.ic_arvalid = 1; bus.ls_arvalid = 1; bus.out_rvalid = 1;
    reset = 1;
    tick(); tick();
    n_checks++; if (bus.ic_arready !== 1'b0) begin n_fail++; $display("FAIL rst_ic_arready got %b want 0", bus.ic_arready); end
    n_checks++; if (bus.ls_arready !== 1'b0) begin n_fail++; $display("FAIL rst_ls_arready got %b want 0", bus.ls_arready); end
    n_checks++; if (bus.out_rready !== 1'b0) begin n_fail++; $display("FAIL rst_out_rready got %b want 0", bus.out_rready); end
    n_checks++; if (bus.ic_rvalid !== 1'b0 || bus.ls_rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_rvalid got ic=%b ls=%b want 0", bus.ic_rvalid, bus.ls_rvalid); end
    clear_inputs();
    #2 reset = 0;
    tick();
    n_checks++; if (bus.out_arvalid !== 1'b0) begin n_fail++; $display("FAIL rst_out_arvalid got %b want 0", bus.out_arvalid); end
    n_checks++; if (bus.out_araddr !== 32'h0) begin n_fail++; $display("FAIL rst_out_araddr got %h want 0", bus.out_araddr); end
    n_checks++; if (bus.out_arsize !== 3'b000) begin n_fail++; $display("FAIL rst_out_arsize got %b want 000", bus.out_arsize); end
    model_last_ls = 0;
  endtask

  task automatic test_ic_alone();
    bus.ic_arvalid = 1; bus.ic_araddr = 32'h3000_0000;
    #1;
    n_checks++; if (bus.ic_arready !== 1'b1) begin n_fail++; $display("FAIL ic_alone_arready got %b want 1", bus.ic_arready); end
    n_checks++; if (bus.ls_arready !== 1'b0) begin n_fail++; $display("FAIL ic_alone_ls_arready got %b want 0", bus.ls_arready); end
    tick();
    model_last_ls = 0;
    bus.ic_arvalid = 0; bus.out_arready = 1; bus.ic_rready = 1;
    bus.out_rvalid = 1; bus.out_rdata = 32'hDEAD_BEEF; bus.out_rresp = 2'b00;
    #1;
    n_checks++; if (bus.out_arvalid !== 1'b1) begin n_fail++; $display("FAIL ic_alone_out_arvalid got %b want 1", bus.out_arvalid); end
    n_checks++; if (bus.out_araddr !== 32'h3000_0000) begin n_fail++; $display("FAIL ic_alone_araddr got %h want 30000000", bus.out_araddr); end
    n_checks++; if (bus.out_arsize !== 3'b010) begin n_fail++; $display("FAIL ic_alone_arsize got %b want 010", bus.out_arsize); end
    n_checks++; if (bus.ic_rvalid !== 1'b0 || bus.out_rready !== 1'b0) begin n_fail++; $display("FAIL ic_alone_addr_stray got rvalid=%b rready=%b want 0 0", bus.ic_rvalid, bus.out_rready); end
    tick();
    #1;
    n_checks++; if (bus.ic_rvalid !== 1'b1) begin n_fail++; $display("FAIL ic_alone_rvalid got %b want 1", bus.ic_rvalid); end
    n_checks++; if (bus.ic_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ic_alone_rdata got %h want deadbeef", bus.ic_rdata); end
    n_checks++; if (bus.ls_rvalid !== 1'b0) begin n_fail++; $display("FAIL ic_alone_ls_rvalid got %b want 0", bus.ls_rvalid); end
    n_checks++; if (bus.out_arvalid !== 1'b0 || bus.out_rready !== 1'b1) begin n_fail++; $display("FAIL ic_alone_data_ctl got arvalid=%b rready=%b want 0 1", bus.out_arvalid, bus.out_rready); end
    tick();
    clear_inputs();
    #1;
    n_checks++; if (bus.ic_rvalid !== 1'b0 || bus.out_rready !== 1'b0) begin n_fail++; $display("FAIL ic_alone_idle got rvalid=%b rready=%b want 0 0", bus.ic_rvalid, bus.out_rready); end
  endtask

  task automatic test_tie();
    for (int r = 0; r < 2; r++) begin
      bit w;
      logic [31:0] d;
      bus.ic_arvalid = 1; bus.ic_araddr = 32'h100; bus.ic_rready = 1;
      bus.ls_arvalid = 1; bus.ls_araddr = 32'h200; bus.ls_arsize = 3'b000; bus.ls_rready = 1;
      w = model_pick_ls(1'b1, 1'b1);
      model_last_ls = w;
      #1;
      n_checks++; if (bus.ls_arready !== w || bus.ic_arready !== !w) begin n_fail++; $display("FAIL tie%0d_grant got ls=%b ic=%b want ls=%b", r, bus.ls_arready, bus.ic_arready, w); end
      tick();
      bus.out_arready = 1;
      #1;
      n_checks++; if (bus.out_araddr !== (w ? 32'h200 : 32'h100)) begin n_fail++; $display("FAIL tie%0d_araddr got %h want %h", r, bus.out_araddr, w ? 32'h200 : 32'h100); end
      n_checks++; if (bus.out_arsize !== (w ? 3'b000 : 3'b010)) begin n_fail++; $display("FAIL tie%0d_arsize got %b", r, bus.out_arsize); end
      n_checks++; if (bus.ic_arready !== 1'b0 || bus.ls_arready !== 1'b0) begin n_fail++; $display("FAIL tie%0d_regrant_addr got ic=%b ls=%b want 0 0", r, bus.ic_arready, bus.ls_arready); end
      tick();
      d = $urandom;
      bus.out_arready = 0; bus.out_rvalid = 1; bus.out_rdata = d;
      #1;
      n_checks++; if (bus.ls_rvalid !== w || bus.ic_rvalid !== !w) begin n_fail++; $display("FAIL tie%0d_route got ls=%b ic=%b want ls=%b", r, bus.ls_rvalid, bus.ic_rvalid, w); end
      n_checks++; if ((w ? bus.ls_rdata : bus.ic_rdata) !== d) begin n_fail++; $display("FAIL tie%0d_rdata got %h want %h", r, w ? bus.ls_rdata : bus.ic_rdata, d); end
      n_checks++; if (bus.ic_arready !== 1'b0 || bus.ls_arready !== 1'b0) begin n_fail++; $display("FAIL tie%0d_regrant_data got ic=%b ls=%b want 0 0", r, bus.ic_arready, bus.ls_arready); end
      tick();
      bus.out_rvalid = 0;
    end
    clear_inputs();
  endtask

  task automatic test_stall();
    bus.ic_arvalid = 1; bus.ic_araddr = 32'h4000_0040;
    #1;
    n_checks++; if (bus.ic_arready !== 1'b1) begin n_fail++; $display("FAIL stall_grant got %b want 1", bus.ic_arready); end
    tick();
    model_last_ls = 0;
    bus.ls_arvalid = 1; bus.ls_araddr = 32'h4400_0000;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_checks++; if (bus.out_arvalid !== 1'b1 || bus.out_araddr !== 32'h4000_0040) begin n_fail++; $display("FAIL stall%0d_hold got arvalid=%b addr=%h want 1 40000040", k, bus.out_arvalid, bus.out_araddr); end
      n_checks++; if (bus.ic_arready !== 1'b0 || bus.ls_arready !== 1'b0) begin n_fail++; $display("FAIL stall%0d_regrant got ic=%b ls=%b want 0 0", k, bus.ic_arready, bus.ls_arready); end
      tick();
    end
    bus.ic_arvalid = 0; bus.ls_arvalid = 0; bus.out_arready = 1;
    tick();
    bus.out_arready = 0; bus.out_rvalid = 1; bus.ic_rready = 1; bus.out_rdata = 32'h1234_5678;
    #1;
    n_checks++; if (bus.ic_rvalid !== 1'b1 || bus.ic_rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL stall_data got rvalid=%b rdata=%h want 1 12345678", bus.ic_rvalid, bus.ic_rdata); end
    tick();
    clear_inputs();
  endtask

  task automatic test_backpressure();
    bus.ls_arvalid = 1; bus.ls_araddr = 32'h5000_0008; bus.ls_arsize = 3'b001;
    #1;
    n_checks++; if (bus.ls_arready !== 1'b1) begin n_fail++; $display("FAIL bp_grant got %b want 1", bus.ls_arready); end
    tick();
    model_last_ls = 1;
    bus.ls_arvalid = 0; bus.out_arready = 1;
    tick();
    bus.out_arready = 0; bus.out_rvalid = 1; bus.out_rdata = 32'h0BAD_F00D; bus.ls_rready = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++; if (bus.out_rready !== 1'b0 || bus.ls_rvalid !== 1'b1) begin n_fail++; $display("FAIL bp%0d_hold got rready=%b rvalid=%b want 0 1", k, bus.out_rready, bus.ls_rvalid); end
      tick();
    end
    bus.ls_rready = 1;
    #1;
    n_checks++; if (bus.out_rready !== 1'b1) begin n_fail++; $display("FAIL bp_release got %b want 1", bus.out_rready); end
    tick();
    bus.out_rvalid = 0; bus.ls_rready = 0; bus.ls_arvalid = 1;
    #1;
    n_checks++; if (bus.ls_arready !== 1'b1 || bus.out_rready !== 1'b0) begin n_fail++; $display("FAIL bp_idle got arready=%b rready=%b want 1 0", bus.ls_arready, bus.out_rready); end
    clear_inputs();
  endtask

  task automatic test_stray();
    tick();
    bus.out_rvalid = 1; bus.out_rresp = 2'b11; bus.out_rdata = 32'hFFFF_0000;
    bus.ic_rready = 1; bus.ls_rready = 1;
    for (int k = 0; k < 2; k++) begin
      #1;
      n_checks++; if (bus.out_rready !== 1'b0 || bus.ic_rvalid !== 1'b0 || bus.ls_rvalid !== 1'b0) begin n_fail++; $display("FAIL stray%0d got rready=%b ic=%b ls=%b want 0 0 0", k, bus.out_rready, bus.ic_rvalid, bus.ls_rvalid); end
      tick();
    end
    bus.out_rvalid = 0;
    bus.ls_arvalid = 1; bus.ls_araddr = 32'h0000_0020; bus.ls_arsize = 3'b010;
    tick();
    model_last_ls = 1;
    bus.ls_arvalid = 0; bus.out_arready = 1;
    tick();
    bus.out_arready = 0; bus.out_rvalid = 1; bus.out_rresp = 2'b10; bus.out_rdata = 32'hCAFE_0001;
    #1;
    n_checks++; if (bus.ls_rresp !== 2'b10) begin n_fail++; $display("FAIL slverr_ls_rresp got %b want 10", bus.ls_rresp); end
    n_checks++; if (bus.ic_rresp !== 2'b00 || bus.ic_rdata !== 32'h0 || bus.ic_rvalid !== 1'b0) begin n_fail++; $display("FAIL slverr_ic_leak got resp=%b data=%h vld=%b want 00 0 0", bus.ic_rresp, bus.ic_rdata, bus.ic_rvalid); end
    tick();
    clear_inputs();
  endtask

  task automatic test_async_reset();
    bus.ic_arvalid = 1; bus.ic_araddr = 32'h6000_0000;
    tick();
    bus.ic_arvalid = 0;
    #1;
    n_checks++; if (bus.out_arvalid !== 1'b1) begin n_fail++; $display("FAIL arst_pre got %b want 1", bus.out_arvalid); end
    #2 reset = 1;
    #1;
    n_checks++; if (bus.out_arvalid !== 1'b0 || bus.out_araddr !== 32'h0) begin n_fail++; $display("FAIL arst_drop got arvalid=%b addr=%h want 0 0", bus.out_arvalid, bus.out_araddr); end
    tick(); tick();
    #2 reset = 0;
    model_last_ls = 0;
    bus.ic_arvalid = 1; bus.ic_araddr = 32'h7000_0004;
    #1;
    n_checks++; if (bus.ic_arready !== 1'b1) begin n_fail++; $display("FAIL arst_regrant got %b want 1", bus.ic_arready); end
    tick();
    bus.ic_arvalid = 0; bus.out_arready = 1;
    #1;
    n_checks++; if (bus.out_arvalid !== 1'b1 || bus.out_araddr !== 32'h7000_0004) begin n_fail++; $display("FAIL arst_addr got arvalid=%b addr=%h want 1 70000004", bus.out_arvalid, bus.out_araddr); end
    tick();
    bus.out_arready = 0; bus.out_rvalid = 1; bus.ic_rready = 1;
    tick();
    clear_inputs();
  endtask

  task automatic test_random();
    for (int it = 0; it < 40; it++) begin
      bit ic_p, ls_p;
      logic [31:0] ia, la;
      logic [2:0]  lsz;
      ic_p = 1'($urandom_range(0, 1)); ls_p = 1'($urandom_range(0, 1));
      if (!ic_p && !ls_p) ic_p = 1;
      ia = $urandom; la = $urandom; lsz = 3'($urandom_range(0, 7));
      while (ic_p || ls_p) begin
        bit w;
        logic [31:0] ea, d;
        logic [2:0]  es;
        logic [1:0]  rs;
        int ad, rvd, rrd, cyc;
        bit done;
        bus.ic_arvalid = ic_p; bus.ic_araddr = ia;
        bus.ls_arvalid = ls_p; bus.ls_araddr = la; bus.ls_arsize = lsz;
        w = model_pick_ls(ic_p, ls_p);
        model_last_ls = w;
        ea = w ? la : ia;
        es = w ? lsz : 3'b010;
        #1;
        n_checks++; if (bus.ls_arready !== w || bus.ic_arready !== (ic_p && !w)) begin n_fail++; $display("FAIL rnd%0d_grant got ic=%b ls=%b want ic=%b ls=%b", it, bus.ic_arready, bus.ls_arready, ic_p && !w, w); end
        tick();
        if (w) ls_p = 0; else ic_p = 0;
        bus.ic_arvalid = ic_p; bus.ls_arvalid = ls_p;
        ad = $urandom_range(0, 3);
        for (int k = 0; k <= ad; k++) begin
          bus.out_arready = (k == ad);
          #1;
          n_checks++; if (bus.out_arvalid !== 1'b1 || bus.out_araddr !== ea || bus.out_arsize !== es) begin n_fail++; $display("FAIL rnd%0d_ar got v=%b a=%h s=%b want 1 %h %b", it, bus.out_arvalid, bus.out_araddr, bus.out_arsize, ea, es); end
          tick();
        end
        bus.out_arready = 0;
        d = $urandom; rs = 2'($urandom_range(0, 3));
        rvd = $urandom_range(0, 2); rrd = $urandom_range(0, 3);
        bus.out_rdata = d; bus.out_rresp = rs;
        cyc = 0; done = 0;
        while (!done) begin
          bit wr;
          wr = (cyc >= rrd);
          bus.out_rvalid = (cyc >= rvd);
          if (w) begin bus.ls_rready = wr; bus.ic_rready = 1'($urandom_range(0, 1)); end
          else   begin bus.ic_rready = wr; bus.ls_rready = 1'($urandom_range(0, 1)); end
          #1;
          n_checks++;
          if (w ? (bus.ls_rvalid !== bus.out_rvalid || bus.ls_rdata !== d || bus.ls_rresp !== rs || bus.ic_rvalid !== 1'b0 || bus.ic_rdata !== 32'h0)
                : (bus.ic_rvalid !== bus.out_rvalid || bus.ic_rdata !== d || bus.ic_rresp !== rs || bus.ls_rvalid !== 1'b0 || bus.ls_rdata !== 32'h0)) begin
            n_fail++; $display("FAIL rnd%0d_r got icv=%b icd=%h lsv=%b lsd=%h want winner_ls=%b d=%h", it, bus.ic_rvalid, bus.ic_rdata, bus.ls_rvalid, bus.ls_rdata, w, d);
          end
          n_checks++; if (bus.out_rready !== wr) begin n_fail++; $display("FAIL rnd%0d_rready got %b want %b", it, bus.out_rready, wr); end
          done = bus.out_rvalid && wr;
          tick();
          cyc++;
        end
        bus.out_rvalid = 0; bus.ic_rready = 0; bus.ls_rready = 0;
      end
      clear_inputs();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ic_alone();
    test_tie();
    test_stall();
    test_backpressure();
    test_stray();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
